// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver and scan code set 2 to ASCII decoder
//
// Ports:
//   clk_in        pixel clock, all logic on its rising edge
//   rst_in        asynchronous active-low reset
//   ps2_clk_in    raw PS/2 clock line (asynchronous)
//   ps2_data_in   raw PS/2 data line (asynchronous)
//   key_pressed   1-cycle pulse, printable key made, character valid
//   enter_pressed 1-cycle pulse, Enter made
//   bksp_pressed  1-cycle pulse, Backspace made
//   character     {8'h00, ASCII}, holds the last printable value
//   frame_err     1-cycle pulse, parity/start/stop error or timeout
//   shift_active  high while either shift key is held
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 74250
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        key_pressed,
  output logic        enter_pressed,
  output logic        bksp_pressed,
  output logic [15:0] character,
  output logic        frame_err,
  output logic        shift_active
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EXT       = 2'd1;
  localparam logic [1:0] S_BREAK     = 2'd2;
  localparam logic [1:0] S_EXT_BREAK = 2'd3;

  logic            clk_s1, clk_s2, clk_hist;
  logic            dat_s1, dat_s2;
  logic            fall_edge;
  logic [3:0]      bit_cnt;
  logic [7:0]      data_sr;
  logic            parity_bit;
  logic [WD_W-1:0] wd_cnt;
  logic            byte_valid;
  logic [1:0]      state;
  logic            shift_l, shift_r;
  logic [7:0]      mapped;

  // Synchronisers reset to 1 (idle bus) so releasing reset never fakes an edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall_edge = clk_hist & ~clk_s2;

  // Frame shifter and watchdog. An edge always wins over watchdog expiry.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt    <= 4'd0;
      data_sr    <= 8'h00;
      parity_bit <= 1'b0;
      wd_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_edge) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (dat_s2) frame_err <= 1'b1;
          else        bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          data_sr <= {dat_s2, data_sr[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          parity_bit <= dat_s2;
          bit_cnt    <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (dat_s2 && ((^data_sr) ^ parity_bit)) byte_valid <= 1'b1;
          else                                     frame_err  <= 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
          bit_cnt   <= 4'd0;
          wd_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // Scan code set 2 (US) to ASCII; 0 means not a printable key.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [15:0] pair;
    pair = 16'h0000;
    case (code)
      8'h1C: pair = {"a", "A"};  8'h32: pair = {"b", "B"};  8'h21: pair = {"c", "C"};
      8'h23: pair = {"d", "D"};  8'h24: pair = {"e", "E"};  8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};  8'h33: pair = {"h", "H"};  8'h43: pair = {"i", "I"};
      8'h3B: pair = {"j", "J"};  8'h42: pair = {"k", "K"};  8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};  8'h31: pair = {"n", "N"};  8'h44: pair = {"o", "O"};
      8'h4D: pair = {"p", "P"};  8'h15: pair = {"q", "Q"};  8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};  8'h2C: pair = {"t", "T"};  8'h3C: pair = {"u", "U"};
      8'h2A: pair = {"v", "V"};  8'h1D: pair = {"w", "W"};  8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};  8'h1A: pair = {"z", "Z"};
      8'h16: pair = {"1", "!"};  8'h1E: pair = {"2", "@"};  8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};  8'h2E: pair = {"5", "%"};  8'h36: pair = {"6", "^"};
      8'h3D: pair = {"7", "&"};  8'h3E: pair = {"8", "*"};  8'h46: pair = {"9", "("};
      8'h45: pair = {"0", ")"};
      8'h0E: pair = {8'h60, "~"};  8'h4E: pair = {"-", "_"};  8'h55: pair = {"=", "+"};
      8'h54: pair = {"[", "{"};  8'h5B: pair = {"]", "}"};  8'h5D: pair = {"\\", "|"};
      8'h4C: pair = {";", ":"};  8'h52: pair = {"'", "\""}; 8'h41: pair = {",", "<"};
      8'h49: pair = {".", ">"};  8'h4A: pair = {"/", "?"};
      8'h29: pair = {" ", " "};
      default: pair = 16'h0000;
    endcase
    return shift ? pair[7:0] : pair[15:8];
  endfunction

  assign shift_active = shift_l | shift_r;
  assign mapped       = scan_to_ascii(data_sr, shift_active);

  // Decoder FSM; only advances on a good byte, so at most one pulse per byte.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      shift_l       <= 1'b0;
      shift_r       <= 1'b0;
      key_pressed   <= 1'b0;
      enter_pressed <= 1'b0;
      bksp_pressed  <= 1'b0;
      character     <= 16'h0000;
    end else begin
      key_pressed   <= 1'b0;
      enter_pressed <= 1'b0;
      bksp_pressed  <= 1'b0;
      if (byte_valid) begin
        case (state)
          S_IDLE: begin
            case (data_sr)
              8'hE0: state <= S_EXT;
              8'hF0: state <= S_BREAK;
              8'h12: shift_l <= 1'b1;
              8'h59: shift_r <= 1'b1;
              8'h5A: enter_pressed <= 1'b1;
              8'h66: bksp_pressed <= 1'b1;
              default: begin
                if (mapped != 8'h00) begin
                  character   <= {8'h00, mapped};
                  key_pressed <= 1'b1;
                end
              end
            endcase
          end
          S_EXT: begin
            if (data_sr == 8'hF0) begin
              state <= S_EXT_BREAK;
            end else begin
              if (data_sr == 8'h5A) enter_pressed <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_BREAK: begin
            if (data_sr == 8'h12) shift_l <= 1'b0;
            if (data_sr == 8'h59) shift_r <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed table-driven bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  localparam int TO = 100;
  localparam int K_NONE = 0, K_KEY = 1, K_ENT = 2, K_BKSP = 3, K_ERR = 4, K_MULTI = 5;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic        key_pressed, enter_pressed, bksp_pressed, frame_err, shift_active;
  logic [15:0] character;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .key_pressed(key_pressed), .enter_pressed(enter_pressed),
    .bksp_pressed(bksp_pressed), .character(character),
    .frame_err(frame_err), .shift_active(shift_active)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        bad_stop;
    int          exp_kind;
    logic [15:0] exp_char;
    logic        exp_shift;
  } vec_t;

  ev_t  ev_q[$];
  vec_t vecs[26];
  int   cyc = 0;
  int   edge_cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Every cycle with any pulse becomes one event; simultaneous pulses are flagged.
  always @(negedge clk_in) begin
    int n;
    int k;
    n = int'(key_pressed) + int'(enter_pressed) + int'(bksp_pressed) + int'(frame_err);
    k = K_NONE;
    if (n > 1)              k = K_MULTI;
    else if (key_pressed)   k = K_KEY;
    else if (enter_pressed) k = K_ENT;
    else if (bksp_pressed)  k = K_BKSP;
    else if (frame_err)     k = K_ERR;
    if (k != K_NONE) ev_q.push_back('{kind: k, cyc: cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par,
                            input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_in);
      ps2_data_in = f[i];
      repeat (6) @(negedge clk_in);
      ps2_clk_in = 1'b0;
      if (i == 10) edge_cyc = cyc;
      repeat (8) @(negedge clk_in);
      ps2_clk_in = 1'b1;
      repeat (6) @(negedge clk_in);
    end
    ps2_data_in = 1'b1;
  endtask

  task automatic check_frame(input string name, input int exp_kind,
                             input logic [15:0] exp_char, input logic exp_shift);
    repeat (6) @(negedge clk_in);
    check({name, " events"}, ev_q.size(), (exp_kind != K_NONE) ? 1 : 0);
    if (ev_q.size() > 0) begin
      check({name, " kind"}, ev_q[0].kind, exp_kind);
      if (ev_q[0].kind >= K_KEY && ev_q[0].kind <= K_BKSP)
        check({name, " latency"}, ev_q[0].cyc - edge_cyc, 4);
    end
    check({name, " character"}, character, exp_char);
    check({name, " shift"}, shift_active, exp_shift);
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, K_KEY,  16'h0061, 1'b0};
    vecs[1]  = '{8'h12, 1'b0, 1'b0, K_NONE, 16'h0061, 1'b1};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, K_KEY,  16'h0041, 1'b1};
    vecs[3]  = '{8'hF0, 1'b0, 1'b0, K_NONE, 16'h0041, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, K_NONE, 16'h0041, 1'b1};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, K_NONE, 16'h0041, 1'b1};
    vecs[6]  = '{8'h12, 1'b0, 1'b0, K_NONE, 16'h0041, 1'b0};
    vecs[7]  = '{8'h1C, 1'b0, 1'b0, K_KEY,  16'h0061, 1'b0};
    vecs[8]  = '{8'h5A, 1'b0, 1'b0, K_ENT,  16'h0061, 1'b0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, K_NONE, 16'h0061, 1'b0};
    vecs[10] = '{8'h5A, 1'b0, 1'b0, K_ENT,  16'h0061, 1'b0};
    vecs[11] = '{8'h66, 1'b0, 1'b0, K_BKSP, 16'h0061, 1'b0};
    vecs[12] = '{8'h1C, 1'b1, 1'b0, K_ERR,  16'h0061, 1'b0};
    vecs[13] = '{8'h1C, 1'b0, 1'b1, K_ERR,  16'h0061, 1'b0};
    vecs[14] = '{8'h16, 1'b0, 1'b0, K_KEY,  16'h0031, 1'b0};
    vecs[15] = '{8'h59, 1'b0, 1'b0, K_NONE, 16'h0031, 1'b1};
    vecs[16] = '{8'h16, 1'b0, 1'b0, K_KEY,  16'h0021, 1'b1};
    vecs[17] = '{8'h29, 1'b0, 1'b0, K_KEY,  16'h0020, 1'b1};
    vecs[18] = '{8'h52, 1'b0, 1'b0, K_KEY,  16'h0022, 1'b1};
    vecs[19] = '{8'hF0, 1'b0, 1'b0, K_NONE, 16'h0022, 1'b1};
    vecs[20] = '{8'h59, 1'b0, 1'b0, K_NONE, 16'h0022, 1'b0};
    vecs[21] = '{8'h4A, 1'b0, 1'b0, K_KEY,  16'h002F, 1'b0};
    vecs[22] = '{8'h4A, 1'b0, 1'b0, K_KEY,  16'h002F, 1'b0};
    vecs[23] = '{8'hE0, 1'b0, 1'b0, K_NONE, 16'h002F, 1'b0};
    vecs[24] = '{8'hF0, 1'b0, 1'b0, K_NONE, 16'h002F, 1'b0};
    vecs[25] = '{8'h5A, 1'b0, 1'b0, K_NONE, 16'h002F, 1'b0};

    // Reset state
    repeat (4) @(negedge clk_in);
    check("reset key", key_pressed, 0);
    check("reset enter", enter_pressed, 0);
    check("reset bksp", bksp_pressed, 0);
    check("reset err", frame_err, 0);
    check("reset character", character, 16'h0000);
    check("reset shift", shift_active, 0);
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("post-reset events", ev_q.size(), 0);

    // Table-driven frames
    for (int v = 0; v < 26; v++) begin
      ev_q.delete();
      send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].bad_stop, 11);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_kind, vecs[v].exp_char, vecs[v].exp_shift);
    end

    // Unmapped make code (Esc) produces nothing
    ev_q.delete();
    send_frame(8'h76, 1'b0, 1'b0, 11);
    check_frame("esc", K_NONE, 16'h002F, 1'b0);

    // Partial frame then stall: watchdog discards it
    ev_q.delete();
    send_frame(8'h32, 1'b0, 1'b0, 5);
    repeat (TO + 40) @(negedge clk_in);
    check("timeout events", ev_q.size(), 1);
    if (ev_q.size() > 0) check("timeout kind", ev_q[0].kind, K_ERR);
    check("timeout bit_cnt", dut.bit_cnt, 0);
    ev_q.delete();
    send_frame(8'h32, 1'b0, 1'b0, 11);
    check_frame("after timeout", K_KEY, 16'h0062, 1'b0);

    // Reset mid-frame with shift held
    ev_q.delete();
    send_frame(8'h12, 1'b0, 1'b0, 11);
    check_frame("shift before reset", K_NONE, 16'h0062, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0, 7);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("midreset shift", shift_active, 0);
    check("midreset character", character, 16'h0000);
    check("midreset bit_cnt", dut.bit_cnt, 0);
    rst_in = 1'b1;
    ev_q.delete();
    send_frame(8'h16, 1'b0, 1'b0, 11);
    check_frame("after midreset", K_KEY, 16'h0031, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
